// File: rtl/mem_pkg.sv
// mem_pkg: shared handshake FSM encoding and width defaults for the memory-access stage.
package mem_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF = 5;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } memState_t;
endpackage

// File: rtl/mem_handshake_fsm.sv
// mem_handshake_fsm: data-memory req/ack sequencer owning state, dmem_req and the load-data register.
module mem_handshake_fsm
    import mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memOp,
    input  logic              isLoad,
    input  logic              dmemAck,
    input  logic [DATA_W-1:0] dmemRdata,
    output logic              dmemReq,
    output logic [DATA_W-1:0] rdataQ,
    output logic              stall,
    output logic              bubble,
    output logic              done,
    output logic              idle
);
    memState_t state, nextState;
    logic start, ackTaken;
    always_comb begin
        idle = state == IDLE;
        done = state == DONE;
        start = idle && memOp;
        ackTaken = state == BUSY && dmemAck;
        bubble = start || state == BUSY;
        stall = bubble;
        nextState = idle ? (memOp ? BUSY : IDLE)
                  : state == BUSY ? (dmemAck ? DONE : BUSY)
                  : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            dmemReq <= 1'b0;
            rdataQ <= '0;
        end else begin
            state <= nextState;
            dmemReq <= start ? 1'b1 : ackTaken ? 1'b0 : dmemReq;
            if (ackTaken && isLoad)
                rdataQ <= dmemRdata;
        end
    end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage stalling on a req/ack data memory; MEM_ALIGN_CHECK_EN adds misaligned-drop.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W = REG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              wb_MemToReg_in,
    input  logic              wb_RegWrite_in,
    input  logic [DATA_W-1:0] ALURes_in,
    input  logic [DATA_W-1:0] WriteData_in,
    input  logic [REG_W-1:0]  RegDest_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              stall,
    output logic              wb_MemToReg_out,
    output logic              wb_RegWrite_out,
    output logic [DATA_W-1:0] MemRes_out,
    output logic [DATA_W-1:0] ALURes_out,
    output logic [REG_W-1:0]  RegDest_out
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              misaligned
`endif
);
    logic memOp, isLoad, fsmMemOp, fsmBubble, fsmDone, fsmIdle, drop, passThru;
    logic [DATA_W-1:0] rdataQ;
    assign memOp = mem_read_in | mem_write_in;
    // a simultaneous read+write is treated as a store, so it never captures read data
    assign isLoad = mem_read_in & ~mem_write_in;
`ifdef MEM_ALIGN_CHECK_EN
    logic badAddr;
    assign badAddr = memOp && ALURes_in[1:0] != 2'b00;
    assign misaligned = fsmIdle && badAddr && !rst;
    assign drop = misaligned;
    assign fsmMemOp = memOp && !badAddr;
`else
    assign drop = 1'b0;
    assign fsmMemOp = memOp;
`endif
    mem_handshake_fsm #(.DATA_W(DATA_W)) u_fsm (
        .clk      (clk),
        .rst      (rst),
        .memOp    (fsmMemOp),
        .isLoad   (isLoad),
        .dmemAck  (dmem_ack),
        .dmemRdata(dmem_rdata),
        .dmemReq  (dmem_req),
        .rdataQ   (rdataQ),
        .stall    (stall),
        .bubble   (fsmBubble),
        .done     (fsmDone),
        .idle     (fsmIdle)
    );
    // real WB controls only for a completed access or a plain ALU op; otherwise a bubble
    assign passThru = fsmDone || (fsmIdle && !fsmBubble && !drop);
    assign wb_RegWrite_out = passThru ? wb_RegWrite_in : 1'b0;
    assign wb_MemToReg_out = passThru ? wb_MemToReg_in : 1'b0;
    assign ALURes_out = ALURes_in;
    assign RegDest_out = RegDest_in;
    assign MemRes_out = rdataQ;
    assign dmem_we = mem_write_in;
    assign dmem_addr = ALURes_in;
    assign dmem_wdata = WriteData_in;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: scoreboard bench for the memory-access stage.
module tb_mem_access_stage;
    logic clk = 1'b0;
    logic rst;
    logic mem_read_in, mem_write_in, wb_MemToReg_in, wb_RegWrite_in;
    logic [31:0] ALURes_in, WriteData_in, dmem_addr, dmem_wdata, dmem_rdata, MemRes_out, ALURes_out;
    logic [4:0] RegDest_in, RegDest_out;
    logic dmem_req, dmem_we, dmem_ack, stall, wb_MemToReg_out, wb_RegWrite_out;
`ifdef MEM_ALIGN_CHECK_EN
    logic misaligned;
`endif
    int passCnt = 0;
    int totalCnt = 0;
    int cyc = 0;
    logic [31:0] rdataModel = 32'h0;

    typedef struct packed {
        logic        regWr;
        logic        memToReg;
        logic [31:0] memRes;
        logic [31:0] alu;
        logic [4:0]  dest;
    } res_t;
    res_t expQ[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mem_access_stage dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read_in    (mem_read_in),
        .mem_write_in   (mem_write_in),
        .wb_MemToReg_in (wb_MemToReg_in),
        .wb_RegWrite_in (wb_RegWrite_in),
        .ALURes_in      (ALURes_in),
        .WriteData_in   (WriteData_in),
        .RegDest_in     (RegDest_in),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_rdata     (dmem_rdata),
        .dmem_ack       (dmem_ack),
        .stall          (stall),
        .wb_MemToReg_out(wb_MemToReg_out),
        .wb_RegWrite_out(wb_RegWrite_out),
        .MemRes_out     (MemRes_out),
        .ALURes_out     (ALURes_out),
        .RegDest_out    (RegDest_out)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .misaligned     (misaligned)
`endif
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs;
        mem_read_in = 1'b0;
        mem_write_in = 1'b0;
        wb_MemToReg_in = 1'b0;
        wb_RegWrite_in = 1'b0;
        ALURes_in = 32'h0;
        WriteData_in = 32'h0;
        RegDest_in = 5'd0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
    endtask

    // Drives one instruction from the next cycle on, answers its memory request after ackDly
    // BUSY cycles, pushes the expected MEM/WB result and returns what the DUT presented once stall dropped.
    task automatic runOp(input logic rd, input logic wr, input logic mtr, input logic rw,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] dest,
                         input int ackDly, input logic [31:0] rdata,
                         output res_t got, output int stallCnt, output int doneCyc,
                         output logic bubbleBad, output logic ctlBad, output logic reqSeen);
        int busy;
        busy = 0;
        step();
        expQ.push_back('{regWr: rw, memToReg: mtr, memRes: (rd && !wr) ? rdata : rdataModel, alu: alu, dest: dest});
        if (rd && !wr) rdataModel = rdata;
        mem_read_in = rd;
        mem_write_in = wr;
        wb_MemToReg_in = mtr;
        wb_RegWrite_in = rw;
        ALURes_in = alu;
        WriteData_in = wd;
        RegDest_in = dest;
        dmem_rdata = rdata;
        dmem_ack = 1'b0;
        got = '{regWr: 1'bx, memToReg: 1'bx, memRes: 'x, alu: 'x, dest: 'x};
        stallCnt = 0;
        doneCyc = -1;
        bubbleBad = 1'b0;
        ctlBad = 1'b0;
        reqSeen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #3;
            reqSeen |= dmem_req;
            if (dmem_we !== wr || dmem_addr !== alu || dmem_wdata !== wd) ctlBad = 1'b1;
            if (stall === 1'b0) begin
                got = '{regWr: wb_RegWrite_out, memToReg: wb_MemToReg_out, memRes: MemRes_out,
                        alu: ALURes_out, dest: RegDest_out};
                doneCyc = cyc;
                break;
            end
            stallCnt++;
            if (wb_RegWrite_out !== 1'b0 || wb_MemToReg_out !== 1'b0) bubbleBad = 1'b1;
            if (dmem_req) busy++;
            dmem_ack = dmem_req && busy == ackDly;
            step();
            dmem_ack = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idleInputs();
        step();
        step();
        #3;
        totalCnt++; if (dmem_req !== 1'b0) $display("FAIL reset_req got %b want 0", dmem_req); else passCnt++;
        totalCnt++; if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall); else passCnt++;
        totalCnt++; if (MemRes_out !== 32'h0) $display("FAIL reset_memres got %h want 0", MemRes_out); else passCnt++;
        rst = 1'b0;
        rdataModel = 32'h0;
    endtask

    task automatic test_alu;
        res_t got, e;
        int st, dc;
        logic bb, cb, rq;
        runOp(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0, 5'd5, 0, 32'h0, got, st, dc, bb, cb, rq);
        e = expQ.pop_front();
        totalCnt++; if (st !== 0) $display("FAIL alu_stall got %0d want 0", st); else passCnt++;
        totalCnt++; if (got !== e) $display("FAIL alu_out got %h want %h", got, e); else passCnt++;
        totalCnt++; if (rq !== 1'b0) $display("FAIL alu_req got %b want 0", rq); else passCnt++;
        step();
        idleInputs();
        #3;
        totalCnt++; if (dmem_req !== 1'b0) $display("FAIL alu_req_after got %b want 0", dmem_req); else passCnt++;
    endtask

    task automatic test_load;
        res_t got, e;
        int st, dc;
        logic bb, cb, rq;
        runOp(1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 5'd3, 1, 32'hDEAD_BEEF, got, st, dc, bb, cb, rq);
        e = expQ.pop_front();
        totalCnt++; if (st !== 2) $display("FAIL load_stall got %0d want 2", st); else passCnt++;
        totalCnt++; if (got !== e) $display("FAIL load_out got %h want %h", got, e); else passCnt++;
        totalCnt++; if (rq !== 1'b1) $display("FAIL load_req got %b want 1", rq); else passCnt++;
        totalCnt++; if (bb !== 1'b0) $display("FAIL load_bubble got %b want 0", bb); else passCnt++;
    endtask

    task automatic test_store;
        res_t got, e;
        int st, dc;
        logic bb, cb, rq;
        runOp(1'b0, 1'b1, 1'b0, 1'b0, 32'h44, 32'h1234_5678, 5'd0, 4, 32'hCAFE_F00D, got, st, dc, bb, cb, rq);
        e = expQ.pop_front();
        totalCnt++; if (st !== 5) $display("FAIL store_stall got %0d want 5", st); else passCnt++;
        totalCnt++; if (got !== e) $display("FAIL store_out got %h want %h", got, e); else passCnt++;
        totalCnt++; if (cb !== 1'b0) $display("FAIL store_ctl_stable got %b want 0", cb); else passCnt++;
        totalCnt++; if (bb !== 1'b0) $display("FAIL store_bubble got %b want 0", bb); else passCnt++;
    endtask

    task automatic test_back_to_back;
        res_t gotA, gotB, e;
        int stA, stB, dcA, dcB;
        logic bb, cb, rq;
        runOp(1'b1, 1'b0, 1'b1, 1'b1, 32'h50, 32'h0, 5'd7, 1, 32'h0000_000A, gotA, stA, dcA, bb, cb, rq);
        runOp(1'b1, 1'b0, 1'b1, 1'b1, 32'h54, 32'h0, 5'd8, 1, 32'h0000_000B, gotB, stB, dcB, bb, cb, rq);
        e = expQ.pop_front();
        totalCnt++; if (gotA !== e) $display("FAIL b2b_first got %h want %h", gotA, e); else passCnt++;
        e = expQ.pop_front();
        totalCnt++; if (gotB !== e) $display("FAIL b2b_second got %h want %h", gotB, e); else passCnt++;
        totalCnt++; if (stB !== 2) $display("FAIL b2b_stall got %0d want 2", stB); else passCnt++;
        totalCnt++; if (dcB - dcA !== 3) $display("FAIL b2b_gap got %0d want 3", dcB - dcA); else passCnt++;
    endtask

    task automatic test_read_write_both;
        res_t got, e;
        int st, dc;
        logic bb, cb, rq;
        runOp(1'b1, 1'b1, 1'b1, 1'b1, 32'h48, 32'h99, 5'd9, 2, 32'h5555_5555, got, st, dc, bb, cb, rq);
        e = expQ.pop_front();
        totalCnt++; if (st !== 3) $display("FAIL both_stall got %0d want 3", st); else passCnt++;
        totalCnt++; if (got !== e) $display("FAIL both_out got %h want %h", got, e); else passCnt++;
    endtask

    task automatic test_reset_mid_busy;
        step();
        idleInputs();
        mem_read_in = 1'b1;
        wb_RegWrite_in = 1'b1;
        ALURes_in = 32'h80;
        step();
        #3;
        totalCnt++; if (dmem_req !== 1'b1) $display("FAIL rstmid_req_before got %b want 1", dmem_req); else passCnt++;
        step();
        rst = 1'b1;
        idleInputs();
        step();
        step();
        rst = 1'b0;
        rdataModel = 32'h0;
        #3;
        totalCnt++; if (dmem_req !== 1'b0) $display("FAIL rstmid_req got %b want 0", dmem_req); else passCnt++;
        totalCnt++; if (stall !== 1'b0) $display("FAIL rstmid_stall got %b want 0", stall); else passCnt++;
        dmem_ack = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        step();
        dmem_ack = 1'b0;
        #3;
        totalCnt++; if (MemRes_out !== rdataModel) $display("FAIL rstmid_late_ack got %h want %h", MemRes_out, rdataModel); else passCnt++;
        totalCnt++; if (stall !== 1'b0 || dmem_req !== 1'b0) $display("FAIL rstmid_after got %b%b want 00", stall, dmem_req); else passCnt++;
    endtask

`ifdef MEM_ALIGN_CHECK_EN
    task automatic test_misaligned;
        step();
        idleInputs();
        mem_read_in = 1'b1;
        wb_RegWrite_in = 1'b1;
        wb_MemToReg_in = 1'b1;
        ALURes_in = 32'h42;
        #3;
        totalCnt++; if (misaligned !== 1'b1) $display("FAIL mis_flag got %b want 1", misaligned); else passCnt++;
        totalCnt++; if (stall !== 1'b0) $display("FAIL mis_stall got %b want 0", stall); else passCnt++;
        totalCnt++; if (wb_RegWrite_out !== 1'b0) $display("FAIL mis_regwrite got %b want 0", wb_RegWrite_out); else passCnt++;
        step();
        idleInputs();
        #3;
        totalCnt++; if (dmem_req !== 1'b0) $display("FAIL mis_req got %b want 0", dmem_req); else passCnt++;
        totalCnt++; if (misaligned !== 1'b0) $display("FAIL mis_clear got %b want 0", misaligned); else passCnt++;
    endtask
`endif

    initial begin
        idleInputs();
        rst = 1'b1;
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_back_to_back();
        test_read_write_both();
        test_reset_mid_busy();
`ifdef MEM_ALIGN_CHECK_EN
        test_misaligned();
`endif
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 5-stage pipeline, between the EX/MEM and MEM/WB pipeline registers.
- Drives a variable-latency data memory through a req/ack handshake and stalls upstream stages until the access completes.
- Every cycle it presents either the completed result or a bubble to MEM/WB, which loads unconditionally.
- Non-memory instructions pass through with zero latency.

Parameters:
- DATA_W, 32, data and address width.
- REG_W, 5, register-destination index width.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_read_in  in  1  load request from EX/MEM.
- mem_write_in  in  1  store request from EX/MEM.
- wb_MemToReg_in  in  1  WB control from EX/MEM.
- wb_RegWrite_in  in  1  WB control from EX/MEM.
- ALURes_in  in  DATA_W  effective address / ALU result.
- WriteData_in  in  DATA_W  store data.
- RegDest_in  in  REG_W  destination register.
- dmem_req  out  1  registered request to data memory.
- dmem_we  out  1  write enable (= mem_write_in).
- dmem_addr  out  DATA_W  = ALURes_in.
- dmem_wdata  out  DATA_W  = WriteData_in.
- dmem_rdata  in  DATA_W  read data; valid when dmem_ack=1.
- dmem_ack  in  1  one-cycle completion pulse.
- stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- wb_MemToReg_out  out  1  to MEM/WB.
- wb_RegWrite_out  out  1  to MEM/WB.
- MemRes_out  out  DATA_W  load data to MEM/WB.
- ALURes_out  out  DATA_W  ALU result to MEM/WB.
- RegDest_out  out  REG_W  destination register to MEM/WB.

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high.
- memop = mem_read_in | mem_write_in.
- FSM has three states: IDLE, BUSY, DONE.
- Reset (including mid-access): state=IDLE, dmem_req=0, rdata_q=0. Any outstanding access is abandoned; a late dmem_ack is ignored because the FSM is not in BUSY.
- IDLE, memop=0:
  - stall=0.
  - Outputs pass through combinationally: wb_* = wb_*_in, ALURes_out = ALURes_in, RegDest_out = RegDest_in, MemRes_out = rdata_q.
- IDLE, memop=1:
  - stall=1 and bubble out (wb_RegWrite_out=0, wb_MemToReg_out=0).
  - Next state BUSY; dmem_req is set to 1 at the same edge.
- BUSY:
  - dmem_req=1, stall=1, bubble out.
  - On dmem_ack=1: rdata_q <= dmem_rdata (loads only; stores leave rdata_q unchanged), dmem_req <= 0, next state DONE.
  - Otherwise hold; no timeout.
- DONE:
  - stall=0.
  - Outputs take the real values from the inputs (held stable by the stall); MemRes_out = rdata_q.
  - Next state IDLE unconditionally. EX/MEM advances at this edge.
- Latency:
  - Non-memory instruction: 0 extra cycles.
  - Memory access: 2 + (cycles until ack) stall cycles. Minimum is ack in the first BUSY cycle: 2 stall cycles, 3 cycles total.
- Back-to-back memory ops: DONE → IDLE, then the new op starts a fresh sequence. Two consecutive DONE cycles never occur.
- dmem_ack outside BUSY is ignored.
- If mem_read_in and mem_write_in are both 1, the access is treated as a write; rdata_q is not updated.
- Bubble values on ALURes_out and RegDest_out are don't-care, but must be driven from the inputs (no X).

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- When defined:
  - A memop with ALURes_in[1:0] != 0 issues no request and raises output misaligned (1 bit) for one cycle in IDLE.
  - That cycle presents a bubble with stall=0 (the instruction is dropped).
  - misaligned resets to 0.
- When undefined: no misaligned port; the address is passed to memory unchanged.

Decomposition:
- Shared package mem_pkg holds the FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and the DATA_W/REG_W defaults.
- One natural sub-module, mem_handshake_fsm: owns state, dmem_req and rdata_q, and produces stall, bubble and done.
- The top level does the output muxing.

Test Plan:
- Reset held 2 cycles mid-BUSY → next cycle state IDLE, dmem_req=0, stall=0; a following ack has no effect.
- ALU op (memop=0, RegWrite=1, ALURes=0x0000_0010, RegDest=5) → same cycle stall=0, outputs equal inputs, dmem_req never 1.
- Load at addr 0x40, ack 1 cycle after req with rdata=0xDEAD_BEEF → stall=1 for exactly 2 cycles; DONE cycle shows RegWrite=1, MemToReg=1, MemRes=0xDEAD_BEEF.
- Store at 0x44, data 0x1234_5678, ack delayed 4 cycles → dmem_we=1, addr/wdata stable throughout, stall 5 cycles, outputs bubble until DONE, rdata_q unchanged.
- Two loads back-to-back (acks return 0xA and 0xB) → two distinct DONE cycles separated by a 2-cycle stall, MemRes 0xA then 0xB.
- With MEM_ALIGN_CHECK_EN: load at 0x42 → misaligned=1 for one cycle, dmem_req stays 0, stall=0, wb_RegWrite_out=0.
